// File: rtl/vedic_pkg.sv
// vedic_pkg: shared types and constants for the sequential Vedic multiplier.
//   state_e    - controller states (IDLE, MUL, DONE)
//   OPW/HW/PW  - operand width, half width, product width
//   NSTEPS     - partial products per multiply
//   STEP_SH    - left shift applied to each step's partial product
//   vedic_mul2 - 2x2 Vedic (Urdhva-Tiryagbhyam) building block
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned OPW    = 8;
  localparam int unsigned HW     = OPW / 2;
  localparam int unsigned PW     = 2 * OPW;
  localparam int unsigned NSTEPS = 4;

  // Entry i is the shift for step i: lo*lo, hi*lo, lo*hi, hi*hi.
  localparam logic [NSTEPS-1:0][3:0] STEP_SH = {4'd8, 4'd4, 4'd4, 4'd0};

  // Vertical and crosswise 2x2: bit0 vertical, bit1 crosswise, bits 3:2
  // vertical high pair plus crosswise carry.
  function automatic logic [3:0] vedic_mul2(input logic [1:0] a, input logic [1:0] b);
    logic v0, x0, x1, c1, v1;
    v0 = a[0] & b[0];
    x0 = a[1] & b[0];
    x1 = a[0] & b[1];
    c1 = x0 & x1;
    v1 = a[1] & b[1];
    return {v1 & c1, v1 ^ c1, x0 ^ x1, v0};
  endfunction

endpackage

// File: rtl/vedic_mul4.sv
// vedic_mul4: combinational 4x4 unsigned Vedic multiplier.
//   x, y - 4-bit unsigned operands
//   p    - 8-bit product
// Four 2x2 Vedic blocks produce partial products that are reduced by two
// carry-save stages and a single final carry-propagate add.
module vedic_mul4
  import vedic_pkg::*;
(
  input  logic [HW-1:0]   x,
  input  logic [HW-1:0]   y,
  output logic [2*HW-1:0] p
);

  logic [3:0] q0, q1, q2, q3;
  logic [7:0] t0, t1, t2, t3;
  logic [7:0] s1, maj1, c1;
  logic [7:0] s2, maj2, c2;

  assign q0 = vedic_mul2(x[1:0], y[1:0]);
  assign q1 = vedic_mul2(x[3:2], y[1:0]);
  assign q2 = vedic_mul2(x[1:0], y[3:2]);
  assign q3 = vedic_mul2(x[3:2], y[3:2]);

  // Partial products aligned to their weights.
  assign t0 = {4'b0000, q0};
  assign t1 = {2'b00, q1, 2'b00};
  assign t2 = {2'b00, q2, 2'b00};
  assign t3 = {q3, 4'b0000};

  // First 3:2 stage on t0..t2.
  assign s1   = t0 ^ t1 ^ t2;
  assign maj1 = (t0 & t1) | (t0 & t2) | (t1 & t2);
  assign c1   = {maj1[6:0], 1'b0};

  // Second 3:2 stage folds in t3. The true product is < 256, so dropping
  // the carry out of bit 7 is exact.
  assign s2   = s1 ^ c1 ^ t3;
  assign maj2 = (s1 & c1) | (s1 & t3) | (c1 & t3);
  assign c2   = {maj2[6:0], 1'b0};

  assign p = s2 + c2;

endmodule

// File: rtl/vedic_mul8_seq.sv
// vedic_mul8_seq: sequential 8x8 unsigned multiplier built on one shared
// 4x4 Vedic core, one cross product per cycle over four cycles.
//   clk, rst_n          - clock, async active-low reset
//   in_valid/in_ready   - operand handshake, in_a/in_b unsigned operands
//   out_valid/out_ready - product handshake, out_p = accumulator
//   busy                - controller not idle
// Only OPW = 8 is supported.
module vedic_mul8_seq #(
  parameter int unsigned OPW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*OPW-1:0] out_p,
  output logic             busy
);
  import vedic_pkg::*;

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [OPW-1:0]   a_q, a_d, b_q, b_d;
  logic [2*OPW-1:0] acc_q, acc_d;

  logic [HW-1:0]    x, y;
  logic [2*HW-1:0]  prod;
  logic [2*OPW-1:0] addend;
  logic             accept;

  // step[0] selects the high half of a, step[1] the high half of b,
  // giving lo*lo, hi*lo, lo*hi, hi*hi.
  assign x = step_q[0] ? a_q[OPW-1:HW] : a_q[HW-1:0];
  assign y = step_q[1] ? b_q[OPW-1:HW] : b_q[HW-1:0];

  vedic_mul4 u_core (
    .x (x),
    .y (y),
    .p (prod)
  );

  assign addend = {{(2*OPW-2*HW){1'b0}}, prod} << STEP_SH[step_q];

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = acc_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MUL;
          step_d  = 2'd0;
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
        end
      end
      MUL: begin
        acc_d  = acc_q + addend;
        step_d = step_q + 2'd1;
        if (step_q == 2'(NSTEPS - 1)) state_d = DONE;
      end
      DONE: begin
        // Handoff straight into MUL when a new pair is waiting.
        if (out_ready) begin
          if (in_valid) begin
            state_d = MUL;
            step_d  = 2'd0;
            a_d     = in_a;
            b_d     = in_b;
            acc_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_vedic_mul8_seq.sv
module tb_vedic_mul8_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_p;
  logic        busy;

  vedic_mul8_seq #(.OPW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] sb[$];
  logic        acc_fire, out_fire;
  logic        s_ovalid, s_iready, s_busy;
  logic [15:0] s_outp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample handshakes just before posedge.
  task automatic tick(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic ordy);
    @(negedge clk);
    in_valid = iv; in_a = a; in_b = b; out_ready = ordy;
    #4;
    s_ovalid = out_valid; s_iready = in_ready; s_busy = busy; s_outp = out_p;
    acc_fire = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (acc_fire) sb.push_back(16'(a) * 16'(b));
    if (out_fire) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("prod", {16'h0, out_p}, {16'h0, sb.pop_front()});
    end
    @(posedge clk);
  endtask

  // Idle-input ticks until out_valid is seen; n = ticks taken.
  task automatic wait_out(input logic ordy, input int max, output int n);
    n = 0;
    do begin
      tick(1'b0, 8'h00, 8'h00, ordy);
      n++;
    end while (!s_ovalid && n < max);
    if (!s_ovalid) chk("timeout_out_valid", 0, 1);
  endtask

  initial begin
    int n;
    int idx;
    int cyc;
    logic [7:0] ra[1000];
    logic [7:0] rb[1000];

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      out_ready = 1'($urandom);
      #4;
      chk("rst_out_valid", {31'h0, out_valid}, 0);
      chk("rst_out_p", {16'h0, out_p}, 0);
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_in_ready", {31'h0, in_ready}, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'h55, 8'hAA, 1'b1);
      chk("idle_busy", {31'h0, s_busy}, 0);
      chk("idle_in_ready", {31'h0, s_iready}, 1);
    end

    // Max operands, 5-cycle latency, single-cycle pulse.
    tick(1'b1, 8'hFF, 8'hFF, 1'b1);
    chk("max_accept", {31'h0, acc_fire}, 1);
    wait_out(1'b1, 10, n);
    chk("max_latency", n, 5);
    chk("max_p", {16'h0, s_outp}, 32'hFE01);
    tick(1'b0, 8'h00, 8'h00, 1'b1);
    chk("max_pulse", {31'h0, s_ovalid}, 0);
    chk("max_idle", {31'h0, s_busy}, 0);

    // Backpressure.
    tick(1'b1, 8'h12, 8'h34, 1'b0);
    wait_out(1'b0, 10, n);
    chk("bp_latency", n, 5);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'($urandom), 8'($urandom), 1'b0);
      chk("bp_valid", {31'h0, s_ovalid}, 1);
      chk("bp_p", {16'h0, s_outp}, 32'h03A8);
      chk("bp_in_ready", {31'h0, s_iready}, 0);
      chk("bp_no_accept", {31'h0, acc_fire}, 0);
    end
    tick(1'b0, 8'h00, 8'h00, 1'b1);
    chk("bp_drain", {31'h0, out_fire}, 1);

    // Back-to-back handoff from DONE.
    tick(1'b1, 8'h05, 8'h07, 1'b0);
    wait_out(1'b0, 10, n);
    tick(1'b1, 8'h0A, 8'h0B, 1'b1);
    chk("b2b_in_ready", {31'h0, s_iready}, 1);
    chk("b2b_accept", {31'h0, acc_fire}, 1);
    n = 0;
    do begin
      tick(1'b0, 8'h00, 8'h00, 1'b1);
      n++;
      if (!s_ovalid) chk("b2b_busy", {31'h0, s_busy}, 1);
    end while (!s_ovalid && n < 10);
    chk("b2b_latency", n, 5);
    chk("b2b_p", {16'h0, s_outp}, 32'h006E);

    // Reset during MUL step 2.
    tick(1'b1, 8'hC3, 8'h5A, 1'b0);
    tick(1'b0, 8'h00, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, out_valid}, 0);
    chk("mid_rst_busy", {31'h0, busy}, 0);
    chk("mid_rst_p", {16'h0, out_p}, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 8'h80, 8'h02, 1'b1);
    wait_out(1'b1, 10, n);
    chk("post_rst_latency", n, 5);
    chk("post_rst_p", {16'h0, s_outp}, 32'h0100);

    // Random traffic.
    for (int i = 0; i < 1000; i++) begin
      ra[i] = 8'($urandom);
      rb[i] = 8'($urandom);
      if (i % 97 == 0) ra[i] = 8'h00;
      if (i % 89 == 0) rb[i] = 8'hFF;
      if (i % 101 == 0) begin ra[i] = 8'hFF; rb[i] = 8'hFF; end
    end
    idx = 0;
    cyc = 0;
    while ((idx < 1000 || sb.size() != 0) && cyc < 40000) begin
      if (idx < 1000)
        tick(($urandom_range(0, 3) != 0), ra[idx], rb[idx], ($urandom_range(0, 9) < 7));
      else
        tick(1'b0, 8'h00, 8'h00, ($urandom_range(0, 9) < 7));
      if (acc_fire) idx++;
      cyc++;
    end
    chk("rand_all_accepted", idx, 1000);
    chk("rand_sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
